// File: rtl/mat_result_uart_tx.sv
// Serialises a captured 2x2 result (or an error marker) as a 4-byte UART packet:
// header, row0, row1, checksum. Frame is 8N1, and each bit lasts CLK_DIV enabled cycles.
module mat_result_uart_tx #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] res_row0,
    input  logic [7:0] res_row1,
    input  logic       err_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    logic [1:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  cap_row0;
    logic [7:0]  cap_row1;
    logic        cap_err;
    logic [7:0]  shreg;
    logic        tx_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  cur_byte;
    logic        baud_tc;

    assign baud_tc = (baud_cnt == BAUD_LAST);

    // Row registers are zeroed at capture on error, so the checksum needs no special case.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            2'd0:    cur_byte = cap_err ? 8'hEE : 8'hA5;
            2'd1:    cur_byte = cap_row0;
            2'd2:    cur_byte = cap_row1;
            default: cur_byte = cap_row0 ^ cap_row1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            cap_row0 <= 8'h00;
            cap_row1 <= 8'h00;
            cap_err  <= 1'b0;
            shreg    <= 8'h00;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!ena) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (start) begin
                        cap_row0 <= err_in ? 8'h00 : res_row0;
                        cap_row1 <= err_in ? 8'h00 : res_row1;
                        cap_err  <= err_in;
                        state    <= S_START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        baud_cnt <= 16'd0;
                        bit_idx  <= 3'd0;
                        byte_idx <= 2'd0;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        baud_cnt <= 16'd0;
                        state    <= S_DATA;
                        bit_idx  <= 3'd0;
                        tx_q     <= cur_byte[0];
                        shreg    <= {1'b0, cur_byte[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= 16'd0;
                        if (byte_idx == 2'd3) begin
                            state    <= S_IDLE;
                            byte_idx <= 2'd0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_START;
                            tx_q     <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    // Masked so a pulse registered just before ena drops is never seen while paused.
    assign done = done_q & ena;

endmodule

// File: doc/mat_result_uart_tx.md
MAT_RESULT_UART_TX -- requirements
Module: mat_result_uart_tx

Interface
REQ-001 Parameter: CLK_DIV, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: ena  input  1  global enable; low freezes all state.
REQ-005 Port: start  input  1  request to capture and transmit one result packet.
REQ-006 Port: res_row0  input  8  row-0 result, {c12[3:0], c11[3:0]}.
REQ-007 Port: res_row1  input  8  row-1 result, {c22[3:0], c21[3:0]}.
REQ-008 Port: err_in  input  1  operand-range error flag from the multiplier.
REQ-009 Port: tx  output  1  serial line, idle high.
REQ-010 Port: busy  output  1  high while a packet is in flight.
REQ-011 Port: done  output  1  one-cycle pulse at packet completion.

Function
REQ-012 The packet SHALL be 4 bytes in order: header, row0 byte, row1 byte, checksum.
REQ-013 err_in=0 at capture: header=0xA5, bytes=res_row0, res_row1, checksum=res_row0 XOR res_row1.
REQ-014 err_in=1 at capture: header=0xEE, row bytes=0x00, checksum=0x00.
REQ-015 Each byte SHALL be framed as start bit 0, 8 data bits LSB first, stop bit 1; 10 bits per byte.
REQ-016 Each bit SHALL hold on tx for exactly CLK_DIV enabled cycles; no idle gap between bytes.
REQ-017 FSM states: IDLE, START, DATA, STOP; IDLE->START on accepted start; START->DATA after CLK_DIV; DATA->STOP after 8 bits; STOP->START if byte index<3, else IDLE.
REQ-018 start SHALL be accepted only in a cycle with ena=1 and FSM in IDLE; res_row0, res_row1, err_in are captured in that cycle.
REQ-019 After acceptance, busy=1 and tx=0 (header start bit) from the next cycle.
REQ-020 start while busy SHALL be ignored; captured data SHALL not change mid-packet when inputs change.
REQ-021 Total packet length SHALL be 40*CLK_DIV enabled cycles from first start-bit cycle to end of last stop bit.
REQ-022 On the edge ending the last stop bit: busy->0, done->1 for exactly one cycle, tx stays 1.
REQ-023 A start asserted in the cycle done=1 SHALL be accepted (FSM is IDLE); the next packet begins the following cycle.
REQ-024 ena=0 SHALL freeze FSM, baud counter, bit/byte indices and tx; done is forced 0 while ena=0; packet resumes where it paused.
REQ-025 Baud counter SHALL count 0..CLK_DIV-1 and wrap; bit index 0..7; byte index 0..3; no other wrap states reachable.
REQ-026 In IDLE tx SHALL be 1.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set tx=1, busy=0, done=0, FSM=IDLE, all counters and capture registers to 0, regardless of ena.
REQ-028 Reset asserted mid-packet SHALL abort the packet without completing the current byte or pulsing done.
REQ-029 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification (CLK_DIV=4)
REQ-030 Reset held 3 cycles -> tx=1, busy=0, done=0 every cycle.
REQ-031 res_row0=0x21, res_row1=0x43, err_in=0, start 1 cycle -> bytes 0xA5, 0x21, 0x43, 0x62 LSB-first; busy high 160 cycles; single done pulse.
REQ-032 err_in=1, res_row0=0xFF, start -> bytes 0xEE, 0x00, 0x00, 0x00; 160 cycles.
REQ-033 start pulsed again and res_row0 changed to 0x99 during byte 1 -> no restart, byte 1 still 0x21, 160 cycles total.
REQ-034 ena=0 for 10 cycles mid data bit of byte 1 -> tx constant during pause, packet content unchanged, completes after 170 cycles.
REQ-035 rst_n=0 mid DATA of byte 2 -> tx=1, busy=0 after that edge, no done; subsequent start sends a full fresh 4-byte packet.
